// File: rtl/mem_access.sv
// rtl/mem_access.sv - Bexkat1 memory stage: Wishbone-classic big-endian data access
module mem_access #(
  parameter int unsigned TIMEOUT = 255,
  parameter logic [3:0]  T_LOAD  = 4'h9,
  parameter logic [3:0]  T_STORE = 4'ha
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [63:0] ir_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] result_i,
  input  logic [31:0] reg_data1_i,
  input  logic [1:0]  reg_write_i,
  output logic [63:0] ir_o,
  output logic [31:0] pc_o,
  output logic [31:0] result_o,
  output logic [1:0]  reg_write_o,
  output logic        stall_o,
  output logic        exc_o,
  output logic        bus_cyc_o,
  output logic        bus_stb_o,
  output logic        bus_we_o,
  output logic [31:0] bus_adr_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_dat_o,
  input  logic [31:0] bus_dat_i,
  input  logic        bus_ack_i,
  input  logic        bus_err_i
);

  typedef enum logic {S_IDLE, S_BUS} state_t;

  // The counter value seen in the last permitted BUS cycle; the bus is
  // therefore held for exactly TIMEOUT cycles when no response arrives.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [31:0] adr_q, adr_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] dat_q, dat_d;
  logic [63:0] ir_q, ir_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] result_q, result_d;
  logic [1:0]  rw_q, rw_d;
  logic        exc_q, exc_d;

  logic [3:0]  ir_type;
  logic [1:0]  ir_width;
  logic        mem_op;
  logic        in_bus;
  logic        timeout;
  logic        fault;
  logic [31:0] fmt_adr;
  logic [3:0]  fmt_sel;
  logic [31:0] fmt_dat;
  logic [31:0] load_data;

  assign ir_type  = ir_i[31:28];
  assign ir_width = ir_i[25:24];
  assign mem_op   = (ir_type == T_LOAD) || (ir_type == T_STORE);
  assign in_bus   = (state_q == S_BUS);
  assign timeout  = in_bus && (cnt_q == TO_LAST);
  // err beats ack; a timeout only counts if ack did not arrive the same cycle
  assign fault    = in_bus && (bus_err_i || (timeout && !bus_ack_i));

  // Hold upstream until the completing cycle; never stall while in reset.
  assign stall_o = !rst_i && mem_op && !(in_bus && (bus_ack_i || bus_err_i || timeout));

  // Address alignment, byte-lane select and store-data replication by width
  always_comb begin
    fmt_adr = {result_i[31:2], 2'b00};
    fmt_sel = 4'b1111;
    fmt_dat = reg_data1_i;
    case (ir_width)
      2'b01: begin
        fmt_adr = {result_i[31:1], 1'b0};
        fmt_sel = result_i[1] ? 4'b0011 : 4'b1100;
        fmt_dat = {reg_data1_i[15:0], reg_data1_i[15:0]};
      end
      2'b10: begin
        fmt_adr = result_i;
        fmt_sel = 4'b1000 >> result_i[1:0];
        fmt_dat = {4{reg_data1_i[7:0]}};
      end
      default: ;
    endcase
  end

  // Pull the selected lanes out of the read word and zero-extend
  always_comb begin
    load_data = bus_dat_i;
    case (sel_q)
      4'b1100: load_data = {16'h0, bus_dat_i[31:16]};
      4'b0011: load_data = {16'h0, bus_dat_i[15:0]};
      4'b1000: load_data = {24'h0, bus_dat_i[31:24]};
      4'b0100: load_data = {24'h0, bus_dat_i[23:16]};
      4'b0010: load_data = {24'h0, bus_dat_i[15:8]};
      4'b0001: load_data = {24'h0, bus_dat_i[7:0]};
      default: ;
    endcase
  end

  // Next-state and next-output logic for the IDLE/BUS controller
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cyc_d    = cyc_q;
    we_d     = we_q;
    adr_d    = adr_q;
    sel_d    = sel_q;
    dat_d    = dat_q;
    ir_d     = ir_q;
    pc_d     = pc_q;
    result_d = result_q;
    rw_d     = rw_q;
    exc_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        pc_d     = pc_i;
        result_d = result_i;
        if (mem_op) begin
          state_d = S_BUS;
          cyc_d   = 1'b1;
          we_d    = (ir_type == T_STORE);
          adr_d   = fmt_adr;
          sel_d   = fmt_sel;
          dat_d   = fmt_dat;
          cnt_d   = 8'h00;
          ir_d    = 64'h0;
          rw_d    = 2'b00;
        end else begin
          ir_d = ir_i;
          rw_d = reg_write_i;
        end
      end
      S_BUS: begin
        cnt_d = cnt_q + 8'h01;
        ir_d  = 64'h0;
        rw_d  = 2'b00;
        if (fault) begin
          // Trap handler needs the faulting instruction and pc, no writeback
          state_d  = S_IDLE;
          cyc_d    = 1'b0;
          exc_d    = 1'b1;
          ir_d     = ir_i;
          pc_d     = pc_i;
          result_d = result_i;
        end else if (bus_ack_i) begin
          state_d  = S_IDLE;
          cyc_d    = 1'b0;
          ir_d     = ir_i;
          pc_d     = pc_i;
          rw_d     = reg_write_i;
          result_d = (ir_type == T_LOAD) ? load_data : result_i;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; async reset drops the bus immediately
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= 8'h00;
      cyc_q    <= 1'b0;
      we_q     <= 1'b0;
      adr_q    <= 32'h0;
      sel_q    <= 4'h0;
      dat_q    <= 32'h0;
      ir_q     <= 64'h0;
      pc_q     <= 32'h0;
      result_q <= 32'h0;
      rw_q     <= 2'b00;
      exc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cyc_q    <= cyc_d;
      we_q     <= we_d;
      adr_q    <= adr_d;
      sel_q    <= sel_d;
      dat_q    <= dat_d;
      ir_q     <= ir_d;
      pc_q     <= pc_d;
      result_q <= result_d;
      rw_q     <= rw_d;
      exc_q    <= exc_d;
    end
  end

  assign ir_o        = ir_q;
  assign pc_o        = pc_q;
  assign result_o    = result_q;
  assign reg_write_o = rw_q;
  assign exc_o       = exc_q;
  assign bus_cyc_o   = cyc_q;
  assign bus_stb_o   = cyc_q;
  assign bus_we_o    = we_q;
  assign bus_adr_o   = adr_q;
  assign bus_sel_o   = sel_q;
  assign bus_dat_o   = dat_q;

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - self-checking bench for mem_access
module tb_mem_access;

  localparam int TO = 8;
  localparam logic [3:0] T_ALU = 4'h6, T_LD = 4'h9, T_ST = 4'ha;
  localparam int M_ACK = 0, M_TO = 1, M_ERRACK = 2, M_ERR = 3;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [63:0] ir_i;
  logic [31:0] pc_i, result_i, reg_data1_i;
  logic [1:0]  reg_write_i;
  logic [63:0] ir_o;
  logic [31:0] pc_o, result_o;
  logic [1:0]  reg_write_o;
  logic        stall_o, exc_o;
  logic        bus_cyc_o, bus_stb_o, bus_we_o;
  logic [31:0] bus_adr_o, bus_dat_o, bus_dat_i;
  logic [3:0]  bus_sel_o;
  logic        bus_ack_i, bus_err_i;

  int n_checks = 0;
  int n_fail   = 0;

  mem_access #(.TIMEOUT(TO), .T_LOAD(T_LD), .T_STORE(T_ST)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ir_i(ir_i), .pc_i(pc_i), .result_i(result_i), .reg_data1_i(reg_data1_i),
    .reg_write_i(reg_write_i),
    .ir_o(ir_o), .pc_o(pc_o), .result_o(result_o), .reg_write_o(reg_write_o),
    .stall_o(stall_o), .exc_o(exc_o),
    .bus_cyc_o(bus_cyc_o), .bus_stb_o(bus_stb_o), .bus_we_o(bus_we_o),
    .bus_adr_o(bus_adr_o), .bus_sel_o(bus_sel_o), .bus_dat_o(bus_dat_o),
    .bus_dat_i(bus_dat_i), .bus_ack_i(bus_ack_i), .bus_err_i(bus_err_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [3:0]  typ;
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  rw;
    int          mode;
    int          delay;
    logic [31:0] rdata;
    logic [31:0] e_adr;
    logic [3:0]  e_sel;
    logic [31:0] e_dato;
    logic        e_we;
    logic [31:0] e_res;
    logic [1:0]  e_rw;
    logic        e_exc;
    int          e_stall;
    int          e_bus;
  } vec_t;

  vec_t vecs[12];
  vec_t exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] typ, input logic [3:0] op, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [1:0] rw, input int mode,
                              input int delay, input logic [31:0] rdata, input logic [31:0] e_adr,
                              input logic [3:0] e_sel, input logic [31:0] e_dato, input logic e_we,
                              input logic [31:0] e_res, input logic [1:0] e_rw, input logic e_exc,
                              input int e_stall, input int e_bus);
    vec_t v;
    v.typ = typ; v.op = op; v.addr = addr; v.wdata = wdata; v.rw = rw; v.mode = mode;
    v.delay = delay; v.rdata = rdata; v.e_adr = e_adr; v.e_sel = e_sel; v.e_dato = e_dato;
    v.e_we = e_we; v.e_res = e_res; v.e_rw = e_rw; v.e_exc = e_exc; v.e_stall = e_stall;
    v.e_bus = e_bus;
    return v;
  endfunction

  function automatic logic [63:0] mk_ir(input logic [3:0] typ, input logic [3:0] op);
    return {32'h0, typ, op, 24'h0};
  endfunction

  // Drive one op at posedge+1, act as the bus slave, then compare on completion
  task automatic run_vec(input int idx, input vec_t v);
    vec_t e;
    int   bus_n;
    int   stall_n;
    bit   done;
    bit   mem;
    mem         = (v.typ == T_LD) || (v.typ == T_ST);
    ir_i        = mk_ir(v.typ, v.op);
    pc_i        = v.addr ^ 32'hF000_0000;
    result_i    = v.addr;
    reg_data1_i = v.wdata;
    reg_write_i = v.rw;
    exp_q.push_back(v);
    bus_n = 0; stall_n = 0; done = 0;
    for (int c = 0; c < 300 && !done; c++) begin
      if (bus_cyc_o) begin
        bus_n++;
        bus_dat_i = v.rdata;
        case (v.mode)
          M_ACK:    bus_ack_i = (bus_n == v.delay + 1);
          M_ERRACK: begin bus_ack_i = (bus_n == v.delay + 1); bus_err_i = bus_ack_i; end
          M_ERR:    bus_err_i = (bus_n == v.delay + 1);
          default:  ;
        endcase
        if (bus_n == 1) begin
          check($sformatf("v%0d adr", idx), 64'(bus_adr_o), 64'(v.e_adr));
          check($sformatf("v%0d sel", idx), 64'(bus_sel_o), 64'(v.e_sel));
          check($sformatf("v%0d we", idx), 64'(bus_we_o), 64'(v.e_we));
          check($sformatf("v%0d stb", idx), 64'(bus_stb_o), 64'(bus_cyc_o));
          check($sformatf("v%0d bubble ir", idx), ir_o, 64'h0);
          if (v.e_we) check($sformatf("v%0d dato", idx), 64'(bus_dat_o), 64'(v.e_dato));
        end
      end
      @(negedge clk_i);
      if (stall_o) stall_n++;
      @(posedge clk_i);
      #1;
      bus_ack_i = 1'b0;
      bus_err_i = 1'b0;
      if (!mem) done = 1;
      else if (bus_n > 0 && !bus_cyc_o) done = 1;
    end
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL v%0d completion: bus still busy after cycle budget, expected completion", idx);
    end
    e = exp_q.pop_front();
    check($sformatf("v%0d result", idx), 64'(result_o), 64'(e.e_res));
    check($sformatf("v%0d reg_write", idx), 64'(reg_write_o), 64'(e.e_rw));
    check($sformatf("v%0d exc", idx), 64'(exc_o), 64'(e.e_exc));
    check($sformatf("v%0d ir", idx), ir_o, mk_ir(e.typ, e.op));
    check($sformatf("v%0d pc", idx), 64'(pc_o), 64'(e.addr ^ 32'hF000_0000));
    check($sformatf("v%0d stall cycles", idx), 64'(stall_n), 64'(e.e_stall));
    check($sformatf("v%0d bus cycles", idx), 64'(bus_n), 64'(e.e_bus));
    ir_i = 64'h0;
    reg_write_i = 2'b00;
    @(posedge clk_i);
    #1;
    check($sformatf("v%0d exc one pulse", idx), 64'(exc_o), 64'h0);
    check($sformatf("v%0d nop ir", idx), ir_o, 64'h0);
  endtask

  initial begin
    vecs[0]  = mk(T_ALU, 4'h0, 32'h1234_5678, 32'h0, 2'b01, M_ACK, 0, 32'h0,
                  32'h0, 4'h0, 32'h0, 1'b0, 32'h1234_5678, 2'b01, 1'b0, 0, 0);
    vecs[1]  = mk(T_LD, 4'h0, 32'h0000_1003, 32'h0, 2'b01, M_ACK, 3, 32'hDEAD_BEEF,
                  32'h0000_1000, 4'hF, 32'h0, 1'b0, 32'hDEAD_BEEF, 2'b01, 1'b0, 4, 4);
    vecs[2]  = mk(T_ST, 4'h2, 32'h0000_2002, 32'h0000_00A5, 2'b00, M_ACK, 0, 32'h0,
                  32'h0000_2002, 4'b0010, 32'hA5A5_A5A5, 1'b1, 32'h0000_2002, 2'b00, 1'b0, 1, 1);
    vecs[3]  = mk(T_LD, 4'h1, 32'h0000_3002, 32'h0, 2'b01, M_ACK, 1, 32'h1111_BEEF,
                  32'h0000_3002, 4'b0011, 32'h0, 1'b0, 32'h0000_BEEF, 2'b01, 1'b0, 2, 2);
    vecs[4]  = mk(T_LD, 4'h2, 32'h0000_3001, 32'h0, 2'b10, M_ACK, 2, 32'h00AB_0000,
                  32'h0000_3001, 4'b0100, 32'h0, 1'b0, 32'h0000_00AB, 2'b10, 1'b0, 3, 3);
    vecs[5]  = mk(T_ST, 4'h1, 32'h0000_4003, 32'h1234_ABCD, 2'b00, M_ACK, 0, 32'h0,
                  32'h0000_4002, 4'b0011, 32'hABCD_ABCD, 1'b1, 32'h0000_4003, 2'b00, 1'b0, 1, 1);
    vecs[6]  = mk(T_ST, 4'h3, 32'h0000_5001, 32'hCAFE_F00D, 2'b00, M_ACK, 0, 32'h0,
                  32'h0000_5000, 4'hF, 32'hCAFE_F00D, 1'b1, 32'h0000_5001, 2'b00, 1'b0, 1, 1);
    vecs[7]  = mk(T_LD, 4'h2, 32'h0000_6003, 32'h0, 2'b01, M_ACK, 0, 32'h1122_33C4,
                  32'h0000_6003, 4'b0001, 32'h0, 1'b0, 32'h0000_00C4, 2'b01, 1'b0, 1, 1);
    vecs[8]  = mk(T_LD, 4'h0, 32'h0000_7000, 32'h0, 2'b01, M_TO, 0, 32'h0,
                  32'h0000_7000, 4'hF, 32'h0, 1'b0, 32'h0000_7000, 2'b00, 1'b1, TO, TO);
    vecs[9]  = mk(T_LD, 4'h0, 32'h0000_8000, 32'h0, 2'b01, M_ERRACK, 1, 32'h5555_5555,
                  32'h0000_8000, 4'hF, 32'h0, 1'b0, 32'h0000_8000, 2'b00, 1'b1, 2, 2);
    vecs[10] = mk(T_ST, 4'h2, 32'h0000_A001, 32'h0000_003C, 2'b00, M_ERR, 0, 32'h0,
                  32'h0000_A001, 4'b0100, 32'h3C3C_3C3C, 1'b1, 32'h0000_A001, 2'b00, 1'b1, 1, 1);
    vecs[11] = mk(T_ALU, 4'h3, 32'h0BAD_F00D, 32'h0, 2'b11, M_ACK, 0, 32'h0,
                  32'h0, 4'h0, 32'h0, 1'b0, 32'h0BAD_F00D, 2'b11, 1'b0, 0, 0);

    rst_i = 1'b1;
    ir_i = 64'h0; pc_i = 32'h0; result_i = 32'h0; reg_data1_i = 32'h0; reg_write_i = 2'b00;
    bus_dat_i = 32'h0; bus_ack_i = 1'b0; bus_err_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check("reset ir_o", ir_o, 64'h0);
    check("reset result_o", 64'(result_o), 64'h0);
    check("reset reg_write_o", 64'(reg_write_o), 64'h0);
    check("reset cyc", 64'(bus_cyc_o), 64'h0);
    check("reset stall", 64'(stall_o), 64'h0);
    check("reset exc", 64'(exc_o), 64'h0);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;

    for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

    // Reset asserted mid-BUS must clear the bus and outputs without a clock edge
    ir_i = mk_ir(T_LD, 4'h0); pc_i = 32'h0000_0900; result_i = 32'h0000_9000; reg_write_i = 2'b01;
    repeat (3) @(posedge clk_i);
    #1;
    check("pre-reset cyc", 64'(bus_cyc_o), 64'h1);
    #2;
    rst_i = 1'b1;
    #1;
    check("async reset cyc", 64'(bus_cyc_o), 64'h0);
    check("async reset stb", 64'(bus_stb_o), 64'h0);
    check("async reset stall", 64'(stall_o), 64'h0);
    check("async reset pc_o", 64'(pc_o), 64'h0);
    check("async reset adr", 64'(bus_adr_o), 64'h0);
    ir_i = 64'h0; reg_write_i = 2'b00;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    run_vec(11, vecs[11]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Bexkat1 pipeline memory stage. Consumes the execute stage's registered outputs (ir, pc, result, reg_data1, reg_write) and performs data-bus reads/writes for T_LOAD/T_STORE.
- Drives a Wishbone-classic big-endian data bus and stalls upstream while a transaction is outstanding.
- Forwards results to writeback: load data, or the execute result for all other types.

Parameters:
- TIMEOUT, 255: cycles to wait for ack/err before aborting the transaction; 8-bit counter.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- ir_i  in  64  instruction from execute; type=[31:28], op=[27:24], size=[0]
- pc_i  in  32  pc from execute
- result_i  in  32  effective address (load/store) or value to write back
- reg_data1_i  in  32  store data
- reg_write_i  in  2  register write enables from execute
- ir_o  out  64  instruction to writeback
- pc_o  out  32  pc to writeback
- result_o  out  32  writeback value
- reg_write_o  out  2  write enables to writeback
- stall_o  out  1  hold execute/earlier stages
- exc_o  out  1  one-cycle bus-fault pulse
- bus_cyc_o  out  1  Wishbone cycle
- bus_stb_o  out  1  Wishbone strobe
- bus_we_o  out  1  write enable
- bus_adr_o  out  32  byte address
- bus_sel_o  out  4  byte lanes; [3] = MSB lane = lowest address
- bus_dat_o  out  32  write data
- bus_dat_i  in  32  read data
- bus_ack_i  in  1  transaction complete
- bus_err_i  in  1  transaction error

Behaviour:
- Reset: all outputs 0 (ir_o=0 is a NOP), state IDLE, timeout counter 0. Reset mid-transaction drops cyc/stb immediately (async). No retry.
- mem_op = (type==T_LOAD || type==T_STORE).
- Width from op[1:0]:
  - 00 word: bus_adr_o[1:0]=00, sel=1111.
  - 01 halfword: adr[0] forced 0, sel = adr[1] ? 0011 : 1100.
  - 10 byte: sel = 1000 >> adr[1:0].
  - 11: treated as word.
- Store data is replicated per width: word as-is, halfword {d[15:0],d[15:0]}, byte {4{d[7:0]}}.
- Load data is extracted from the selected lanes and zero-extended to 32 bits.
- FSM:
  - IDLE: non-mem_op → pass-through, 1-cycle latency: ir_o/pc_o/result_o/reg_write_o <= inputs. mem_op → next edge enters BUS with cyc=stb=1, we=(T_STORE), adr/sel/dat_o registered from inputs, counter cleared. Outputs load a bubble (ir_o=0, reg_write_o=0).
  - BUS: cyc/stb held with stable adr/sel/we/dat_o; counter increments each cycle. On ack: cyc=stb=0 at that edge, state → IDLE. ir_o/pc_o/reg_write_o <= inputs. result_o <= extracted load data (load) or result_i (store). Bubble emitted while waiting.
  - On err, or counter==TIMEOUT without ack: cyc=stb=0, state → IDLE, exc_o=1 for one cycle, reg_write_o=0, ir_o=ir_i (so the trap handler sees the faulting pc_o/ir_o).
- ack and err in the same cycle: err wins.
- stall_o is combinational = mem_op & ~(state==BUS & (bus_ack_i | bus_err_i | timeout)). It is therefore high in the IDLE cycle a mem_op arrives and low on the completing cycle, so upstream advances on the same edge the result is captured.
- Inputs are guaranteed stable while stall_o=1. Back-to-back mem ops: the next one enters BUS on the edge after completion; minimum 2 cycles per mem op (IDLE→BUS→ack).
- cyc and stb are always equal. No pipelined Wishbone; single outstanding transaction.
- Store writes no register; the reg_write_i value is passed through unmodified (execute already zeroes it for stores).

Test Plan:
- ALU op (type T_ALU, result_i=0x12345678, reg_write_i=01): next cycle result_o=0x12345678, reg_write_o=01, stall_o=0, cyc never asserted.
- Word load, result_i=0x00001003, ack 3 cycles after stb with dat_i=0xDEADBEEF → bus_adr_o=0x00001000, sel=1111, we=0; stall_o high 4 cycles; result_o=0xDEADBEEF; bubble (ir_o=0) during wait.
- Byte store, addr 0x2002, reg_data1_i=0x000000A5, immediate ack → sel=0010, dat_o=0xA5A5A5A5, we=1; completes in 2 cycles.
- Halfword load, addr 0x3002, dat_i=0x1111BEEF → sel=0011, result_o=0x0000BEEF. Byte load at 0x3001, dat_i=0x00AB0000 → result_o=0x000000AB.
- No ack, TIMEOUT=8 → cyc drops after 8 BUS cycles; exc_o pulses once; reg_write_o=0; stall releases. Repeat with err and ack asserted together → exc_o=1, load data discarded.
- rst_i asserted mid-BUS → cyc/stb/stall_o and all outputs 0 immediately. After release, a pass-through op completes normally.
